// File: rtl/p405s_utlb_pkg.sv
// rtl/p405s_utlb_pkg.sv - shared types and op/source codes for the UTLB access scheduler
package p405s_utlb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LKUP = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SRC_EXE = 2'b00,
        SRC_D   = 2'b01,
        SRC_I   = 2'b10
    } src_t;

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_SX = 2'b10;

    // Reserved opcode 11 is executed as a search.
    function automatic state_t opState(input logic [1:0] op);
        case (op)
            OP_RD:   return RD;
            OP_WR:   return WR;
            OP_SX:   return LKUP;
            default: return LKUP;
        endcase
    endfunction

    function automatic int maxCyc(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/p405s_utlb_access_sched_if.sv
// rtl/p405s_utlb_access_sched_if.sv - requester handshakes and UTLB array controls
interface p405s_utlb_access_sched_if;
    logic       exeReq;
    logic [1:0] exeOp;
    logic       exeAck;
    logic       dReq;
    logic       dAck;
    logic       iReq;
    logic       iAck;
    logic       TestM3;
    logic       rdEn;
    logic       wrEn;
    logic       lookupEn;
    logic       LookupenForEnC1;
    logic       opDone;
    logic [1:0] opSrc;
    logic       busy;

    modport master (
        output exeReq, exeOp, dReq, iReq, TestM3,
        input  exeAck, dAck, iAck, rdEn, wrEn, lookupEn, LookupenForEnC1, opDone, opSrc, busy
    );

    modport slave (
        input  exeReq, exeOp, dReq, iReq, TestM3,
        output exeAck, dAck, iAck, rdEn, wrEn, lookupEn, LookupenForEnC1, opDone, opSrc, busy
    );
endinterface

// File: rtl/p405s_utlb_age_ctr.sv
// rtl/p405s_utlb_age_ctr.sv - saturating wait counter that flags a starved instruction-side request
module p405s_utlb_age_ctr #(
    parameter int AGE_MAX = 8
) (
    input  logic CB,
    input  logic reset_n,
    input  logic req,
    input  logic ack,
    output logic aged
);
    localparam int AW = $clog2(AGE_MAX + 1);
    localparam logic [AW-1:0] AGE_TOP = AW'(AGE_MAX);

    logic [AW-1:0] age;

    always_ff @(posedge CB or negedge reset_n) begin
        if (!reset_n) begin
            age <= '0;
        end else if (!req || ack) begin
            age <= '0;
        end else if (age != AGE_TOP) begin
            age <= age + AW'(1);
        end
    end

    assign aged = (age == AGE_TOP);
endmodule

// File: rtl/p405s_utlb_access_sched.sv
// rtl/p405s_utlb_access_sched.sv - single-issue arbiter and sequencer for the shared UTLB array
import p405s_utlb_pkg::*;

module p405s_utlb_access_sched #(
    parameter int LKUP_CYC = 2,
    parameter int RD_CYC   = 1,
    parameter int WR_CYC   = 2,
    parameter int AGE_MAX  = 8
) (
    input  logic CB,
    input  logic reset_n,
    p405s_utlb_access_sched_if.slave bus
);
    localparam int MAX_CYC = maxCyc(LKUP_CYC, RD_CYC, WR_CYC);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_t           state, nextState;
    logic [CNT_W-1:0] cnt, nextCnt;
    src_t             curSrc, nextSrc;
    logic             exeAckC, dAckC, iAckC;
    logic             aged;
    logic             opDoneQ;
    logic [1:0]       opSrcQ;

    function automatic logic [CNT_W-1:0] opLen(input state_t s);
        case (s)
            LKUP:    return CNT_W'(LKUP_CYC - 1);
            RD:      return CNT_W'(RD_CYC - 1);
            WR:      return CNT_W'(WR_CYC - 1);
            default: return '0;
        endcase
    endfunction

    p405s_utlb_age_ctr #(.AGE_MAX(AGE_MAX)) ageCtr (
        .CB     (CB),
        .reset_n(reset_n),
        .req    (bus.iReq),
        .ack    (iAckC),
        .aged   (aged)
    );

    // Grants are taken in IDLE or in the last cycle of an op so back-to-back ops lose no cycle.
    always_comb begin
        nextState = state;
        nextCnt   = cnt - CNT_W'(1);
        nextSrc   = curSrc;
        exeAckC   = 1'b0;
        dAckC     = 1'b0;
        iAckC     = 1'b0;
        if (state == IDLE || cnt == '0) begin
            nextState = IDLE;
            nextCnt   = '0;
            if (!bus.TestM3 && reset_n) begin
                if (bus.iReq && aged) begin
                    iAckC     = 1'b1;
                    nextState = LKUP;
                    nextSrc   = SRC_I;
                end else if (bus.exeReq) begin
                    exeAckC   = 1'b1;
                    nextState = opState(bus.exeOp);
                    nextSrc   = SRC_EXE;
                end else if (bus.dReq) begin
                    dAckC     = 1'b1;
                    nextState = LKUP;
                    nextSrc   = SRC_D;
                end else if (bus.iReq) begin
                    iAckC     = 1'b1;
                    nextState = LKUP;
                    nextSrc   = SRC_I;
                end
                if (nextState != IDLE) begin
                    nextCnt = opLen(nextState);
                end
            end
        end
    end

    always_ff @(posedge CB or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            curSrc  <= SRC_EXE;
            opDoneQ <= 1'b0;
            opSrcQ  <= 2'b00;
        end else begin
            state   <= nextState;
            cnt     <= nextCnt;
            curSrc  <= nextSrc;
            opDoneQ <= (state != IDLE) && (cnt == '0);
            if (state != IDLE && cnt == '0) begin
                opSrcQ <= curSrc;
            end
        end
    end

    assign bus.exeAck          = exeAckC;
    assign bus.dAck            = dAckC;
    assign bus.iAck            = iAckC;
    assign bus.rdEn            = (state == RD);
    assign bus.wrEn            = (state == WR);
    assign bus.lookupEn        = (state == LKUP);
    assign bus.LookupenForEnC1 = (nextState == LKUP);
    assign bus.opDone          = opDoneQ;
    assign bus.opSrc           = opSrcQ;
    assign bus.busy            = (state != IDLE);
endmodule

// File: tb/tb_p405s_utlb_access_sched.sv
// tb/tb_p405s_utlb_access_sched.sv - directed and soak bench for the UTLB access scheduler
module tb_p405s_utlb_access_sched;
    logic CB = 1'b0;
    logic reset_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    always #5 CB = ~CB;

    p405s_utlb_access_sched_if bus ();

    p405s_utlb_access_sched dut (
        .CB     (CB),
        .reset_n(reset_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge CB);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic setIn(input logic e, input logic [1:0] op, input logic d, input logic i, input logic t);
        bus.exeReq = e;
        bus.exeOp  = op;
        bus.dReq   = d;
        bus.iReq   = i;
        bus.TestM3 = t;
    endtask

    task automatic idleWait(input string tag);
        for (int k = 0; k < 20; k++) begin
            cyc();
            mid();
            if (!bus.busy && !bus.opDone) break;
        end
        chk(tag, {bus.busy, bus.opDone}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] q[$];
    logic [1:0] expSrc;
    logic       eA, dA, iA;

    initial begin
        setIn(0, 2'b00, 0, 0, 0);
        repeat (2) @(posedge CB);
        #1;
        chk("rst busy", bus.busy, 0);
        chk("rst enables", {bus.rdEn, bus.wrEn, bus.lookupEn}, 3'b000);
        chk("rst opDone", bus.opDone, 0);
        chk("rst opSrc", bus.opSrc, 2'b00);
        chk("rst acks", {bus.exeAck, bus.dAck, bus.iAck}, 3'b000);
        cyc();
        reset_n = 1'b1;

        // single data-side lookup
        cyc(); setIn(0, 2'b00, 1, 0, 0); mid();
        chk("s1 dAck c0", bus.dAck, 1);
        chk("s1 C1 c0", bus.LookupenForEnC1, 1);
        chk("s1 lookupEn c0", bus.lookupEn, 0);
        cyc(); setIn(0, 2'b00, 0, 0, 0); mid();
        chk("s1 lookupEn c1", bus.lookupEn, 1);
        chk("s1 C1 c1", bus.LookupenForEnC1, 1);
        chk("s1 busy c1", bus.busy, 1);
        cyc(); mid();
        chk("s1 lookupEn c2", bus.lookupEn, 1);
        chk("s1 C1 c2", bus.LookupenForEnC1, 0);
        chk("s1 opDone c2", bus.opDone, 0);
        cyc(); mid();
        chk("s1 lookupEn c3", bus.lookupEn, 0);
        chk("s1 opDone c3", bus.opDone, 1);
        chk("s1 opSrc c3", bus.opSrc, 2'b01);
        cyc(); mid();
        chk("s1 opDone c4", bus.opDone, 0);

        // exe write, data and instr requests together
        cyc(); setIn(1, 2'b01, 1, 1, 0); mid();
        chk("s2 acks c0", {bus.exeAck, bus.dAck, bus.iAck}, 3'b100);
        cyc(); setIn(0, 2'b01, 1, 1, 0); mid();
        chk("s2 wrEn c1", bus.wrEn, 1);
        chk("s2 dAck c1", bus.dAck, 0);
        cyc(); mid();
        chk("s2 wrEn c2", bus.wrEn, 1);
        chk("s2 acks c2", {bus.exeAck, bus.dAck, bus.iAck}, 3'b010);
        chk("s2 C1 c2", bus.LookupenForEnC1, 1);
        cyc(); setIn(0, 2'b00, 0, 1, 0); mid();
        chk("s2 en c3", {bus.rdEn, bus.wrEn, bus.lookupEn}, 3'b001);
        chk("s2 opDone c3", {bus.opDone, bus.opSrc}, 3'b100);
        chk("s2 iAck c3", bus.iAck, 0);
        cyc(); mid();
        chk("s2 iAck c4", bus.iAck, 1);
        cyc(); setIn(0, 2'b00, 0, 0, 0); mid();
        chk("s2 lookupEn c5", bus.lookupEn, 1);
        chk("s2 opDone c5", {bus.opDone, bus.opSrc}, 3'b101);
        cyc(); cyc(); mid();
        chk("s2 opDone c7", {bus.opDone, bus.opSrc}, 3'b110);
        idleWait("s2 idle");

        // starvation: exe and data keep winning until the instr request ages out
        cyc(); setIn(1, 2'b10, 1, 1, 0);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) cyc();
            mid();
            if (k == 4) chk("s3 age c4", dut.ageCtr.age, 4);
            if (k == 6) chk("s3 acks c6", {bus.exeAck, bus.dAck, bus.iAck}, 3'b100);
            if (k == 8) chk("s3 acks c8", {bus.exeAck, bus.dAck, bus.iAck}, 3'b001);
        end
        cyc(); setIn(0, 2'b00, 0, 0, 0); mid();
        chk("s3 age after iAck", dut.ageCtr.age, 0);
        chk("s3 opDone exe", {bus.opDone, bus.opSrc}, 3'b100);
        cyc(); cyc(); mid();
        chk("s3 opDone instr", {bus.opDone, bus.opSrc}, 3'b110);
        idleWait("s3 idle");

        // test mode blocks new grants but lets the current lookup finish
        cyc(); setIn(0, 2'b00, 1, 0, 0); mid();
        chk("s4 dAck c0", bus.dAck, 1);
        cyc(); setIn(0, 2'b00, 0, 0, 1); mid();
        chk("s4 lookupEn c1", bus.lookupEn, 1);
        cyc(); setIn(0, 2'b00, 1, 0, 1); mid();
        chk("s4 blocked c2", bus.dAck, 0);
        cyc(); mid();
        chk("s4 opDone c3", {bus.opDone, bus.opSrc, bus.busy, bus.dAck}, 5'b10100);
        cyc(); mid();
        chk("s4 blocked c4", {bus.dAck, bus.busy}, 2'b00);
        cyc(); setIn(0, 2'b00, 1, 0, 0); mid();
        chk("s4 dAck release", bus.dAck, 1);
        cyc(); setIn(0, 2'b00, 0, 0, 0);
        idleWait("s4 idle");

        // reset in the middle of a write
        cyc(); setIn(1, 2'b01, 0, 0, 0); mid();
        chk("s5 exeAck", bus.exeAck, 1);
        cyc(); setIn(0, 2'b00, 0, 0, 0); mid();
        chk("s5 wrEn before rst", bus.wrEn, 1);
        reset_n = 1'b0;
        #1;
        chk("s5 wrEn/busy in rst", {bus.wrEn, bus.busy}, 2'b00);
        cyc(); mid();
        chk("s5 no opDone", {bus.opDone, bus.opSrc}, 3'b000);
        cyc(); reset_n = 1'b1; mid();
        chk("s5 no opDone post", {bus.opDone, bus.busy}, 2'b00);
        cyc(); setIn(1, 2'b00, 0, 0, 0); mid();
        chk("s5 rd exeAck", bus.exeAck, 1);
        cyc(); setIn(0, 2'b00, 0, 0, 0); mid();
        chk("s5 rdEn", {bus.rdEn, bus.wrEn, bus.lookupEn}, 3'b100);
        cyc(); mid();
        chk("s5 rd done", {bus.rdEn, bus.opDone, bus.opSrc}, 4'b0100);

        // random soak with a requester model that holds each request until its ack
        eA = 0; dA = 0; iA = 0;
        for (int n = 0; n < 420; n++) begin
            cyc();
            if (n >= 400) begin
                setIn(0, 2'b00, 0, 0, 0);
            end else begin
                if (bus.exeReq && eA) bus.exeReq = 0;
                else if (!bus.exeReq && $urandom_range(0, 2) == 0) begin
                    bus.exeReq = 1;
                    bus.exeOp  = 2'($urandom_range(0, 3));
                end
                if (bus.dReq && dA) bus.dReq = 0;
                else if (!bus.dReq && $urandom_range(0, 2) == 0) bus.dReq = 1;
                if (bus.iReq && iA) bus.iReq = 0;
                else if (!bus.iReq && $urandom_range(0, 2) == 0) bus.iReq = 1;
                bus.TestM3 = ($urandom_range(0, 7) == 0);
            end
            mid();
            chk("soak exclusive", (int'(bus.rdEn) + int'(bus.wrEn) + int'(bus.lookupEn)) <= 1, 1);
            if (bus.opDone) begin
                if (q.size() > 0) begin
                    expSrc = q.pop_front();
                    chk("soak opSrc", bus.opSrc, expSrc);
                end else begin
                    chk("soak orphan opDone", bus.opDone, 0);
                end
            end
            eA = bus.exeAck; dA = bus.dAck; iA = bus.iAck;
            if (eA) q.push_back(2'b00);
            if (dA) q.push_back(2'b01);
            if (iA) q.push_back(2'b10);
        end
        chk("soak drained", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
